// File: rtl/cpu_pkg.sv
// Shared execute-stage definitions: multiply op encodings, flag indices,
// flag-group write masks and the multiply FSM state type.
package cpu_pkg;

  localparam logic [2:0] MUL_OP_MUL   = 3'b000;
  localparam logic [2:0] MUL_OP_MLA   = 3'b001;
  localparam logic [2:0] MUL_OP_UMULL = 3'b100;
  localparam logic [2:0] MUL_OP_UMLAL = 3'b101;
  localparam logic [2:0] MUL_OP_SMULL = 3'b110;
  localparam logic [2:0] MUL_OP_SMLAL = 3'b111;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

  localparam logic [2:0] FW_NZ = 3'b100;
  localparam logic [2:0] FW_CV = 3'b010;
  localparam logic [2:0] FW_Q  = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_MUL  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } mul_state_e;

  // Request fields captured at accept and held for the whole operation
  typedef struct packed {
    logic [2:0]  op;
    logic        set_flags;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
  } mul_req_t;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

  function automatic logic is_long(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/mul_step.sv
// Combinational shift-add step: adds multiplicand << i for every set
// multiplier bit i of the current BITS_PER_CYCLE-wide slice.
module mul_step
  #(parameter int BITS_PER_CYCLE = 1)
  (
  input  logic [63:0]               mcand_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  input  logic [63:0]               prod_i,
  output logic [63:0]               prod_o
);

  logic [BITS_PER_CYCLE-1:0][63:0] pp;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_pp
    assign pp[i] = bits_i[i] ? (mcand_i << i) : 64'd0;
  end

  always_comb begin
    prod_o = prod_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) prod_o = prod_o + pp[i];
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative multiply / multiply-accumulate unit: sign-magnitude shift-add
// core, final negate + accumulate in ACC, N/Z flag generation.
module mul_unit
  import cpu_pkg::*;
  #(parameter int BITS_PER_CYCLE = 1)
  (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        Flush,
  input  logic [2:0]  Op,
  input  logic        SetFlags,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [31:0] AccLo,
  input  logic [31:0] AccHi,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ResultLo,
  output logic [31:0] ResultHi,
  output logic [4:0]  MulFlags,
  output logic [2:0]  MulFlagsWrite
);

  localparam int         N        = 32 / BITS_PER_CYCLE;
  localparam int         CNT_W    = 5;
  localparam logic [4:0] CNT_INIT = CNT_W'(N - 1);

  mul_state_e  state_q, state_d;
  mul_req_t    req_q;
  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic        neg_q;
  logic [63:0] prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] res_lo_q, res_hi_q;
  logic [4:0]  flags_q;

  logic        accept;
  logic [63:0] step_prod;
  logic [63:0] prod_fix, addend, acc_res;
  logic [4:0]  acc_flags;

  assign accept = (state_q == S_IDLE) && Start && !Flush;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (Start && !Flush) state_d = S_PREP;
      S_PREP: state_d = Flush ? S_IDLE : S_MUL;
      S_MUL: begin
        if (Flush)           state_d = S_IDLE;
        else if (cnt_q == 0) state_d = S_ACC;
      end
      S_ACC:  state_d = Flush ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  mul_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .mcand_i (mcand_q),
    .bits_i  (mplier_q[BITS_PER_CYCLE-1:0]),
    .prod_i  (prod_q),
    .prod_o  (step_prod)
  );

  // Final fix-up: restore sign, then add the accumulator the op asks for
  always_comb begin
    prod_fix = neg_q ? (~prod_q + 64'd1) : prod_q;
    addend   = 64'd0;
    if (req_q.op == MUL_OP_MLA)
      addend = {32'd0, req_q.acc_lo};
    else if (req_q.op == MUL_OP_UMLAL || req_q.op == MUL_OP_SMLAL)
      addend = {req_q.acc_hi, req_q.acc_lo};
    acc_res   = prod_fix + addend;
    acc_flags = 5'd0;
    if (is_long(req_q.op)) begin
      acc_flags[FLAG_N] = acc_res[63];
      acc_flags[FLAG_Z] = (acc_res == 64'd0);
    end else begin
      acc_flags[FLAG_N] = acc_res[31];
      acc_flags[FLAG_Z] = (acc_res[31:0] == 32'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      req_q    <= '0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      neg_q    <= 1'b0;
      prod_q   <= 64'd0;
      cnt_q    <= '0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      flags_q  <= 5'd0;
    end else begin
      unique case (state_q)
        S_IDLE: if (accept) begin
          req_q.op        <= Op;
          req_q.set_flags <= SetFlags;
          req_q.acc_lo    <= AccLo;
          req_q.acc_hi    <= AccHi;
          mcand_q         <= {32'd0, SrcA};
          mplier_q        <= SrcB;
        end
        S_PREP: begin
          if (is_signed(req_q.op)) begin
            mcand_q  <= {32'd0, abs32(mcand_q[31:0])};
            mplier_q <= abs32(mplier_q);
            neg_q    <= mcand_q[31] ^ mplier_q[31];
          end else begin
            neg_q    <= 1'b0;
          end
          prod_q <= 64'd0;
          cnt_q  <= CNT_INIT;
        end
        S_MUL: begin
          prod_q   <= step_prod;
          mcand_q  <= mcand_q << BITS_PER_CYCLE;
          mplier_q <= mplier_q >> BITS_PER_CYCLE;
          cnt_q    <= cnt_q - 1'b1;
        end
        S_ACC: if (!Flush) begin
          res_lo_q <= acc_res[31:0];
          res_hi_q <= is_long(req_q.op) ? acc_res[63:32] : 32'd0;
          flags_q  <= acc_flags;
        end
        default: ;
      endcase
    end
  end

  assign Busy          = (state_q == S_PREP) || (state_q == S_MUL) || (state_q == S_ACC);
  assign Done          = (state_q == S_DONE);
  assign ResultLo      = res_lo_q;
  assign ResultHi      = res_hi_q;
  assign MulFlags      = flags_q;
  // A flush landing on DONE still completes but must not write flags
  assign MulFlagsWrite = (Done && req_q.set_flags && !Flush) ? FW_NZ : 3'b000;

endmodule

// File: tb/tb_mul_unit.sv
// Directed-vector bench for mul_unit (BITS_PER_CYCLE=1).
module tb_mul_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Start, Flush, SetFlags;
  logic [2:0]  Op;
  logic [31:0] SrcA, SrcB, AccLo, AccHi;
  logic        Busy, Done;
  logic [31:0] ResultLo, ResultHi;
  logic [4:0]  MulFlags;
  logic [2:0]  MulFlagsWrite;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mul_unit #(.BITS_PER_CYCLE(1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .Start         (Start),
    .Flush         (Flush),
    .Op            (Op),
    .SetFlags      (SetFlags),
    .SrcA          (SrcA),
    .SrcB          (SrcB),
    .AccLo         (AccLo),
    .AccHi         (AccHi),
    .Busy          (Busy),
    .Done          (Done),
    .ResultLo      (ResultLo),
    .ResultHi      (ResultHi),
    .MulFlags      (MulFlags),
    .MulFlagsWrite (MulFlagsWrite)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; issues Start now, accept at next edge
  task automatic run_op(input string tag, input logic [2:0] op, input logic sf,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] alo, input logic [31:0] ahi,
                        input logic [63:0] exp, input logic [4:0] exp_fl,
                        input bit flush_done = 0, input bit start_done = 0);
    int k;
    Op = op; SetFlags = sf; SrcA = a; SrcB = b; AccLo = alo; AccHi = ahi;
    Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    Op = $urandom; SetFlags = $urandom; SrcA = $urandom; SrcB = $urandom;
    AccLo = $urandom; AccHi = $urandom;
    chk({tag, ".busy"}, 64'(Busy), 64'd1);
    k = 0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (Done) begin k = c; break; end
    end
    chk({tag, ".lat"}, 64'(k), 64'd34);
    if (flush_done) Flush = 1'b1;
    if (start_done) Start = 1'b1;
    #1;
    chk({tag, ".done"}, 64'(Done), 64'd1);
    chk({tag, ".fw"}, 64'(MulFlagsWrite), (sf && !flush_done) ? 64'd4 : 64'd0);
    chk({tag, ".lo"}, 64'(ResultLo), 64'(exp[31:0]));
    chk({tag, ".hi"}, 64'(ResultHi), 64'(exp[63:32]));
    chk({tag, ".fl"}, 64'(MulFlags), 64'(exp_fl));
    @(posedge clk); #1;
    Flush = 1'b0; Start = 1'b0;
    chk({tag, ".done1"}, 64'(Done), 64'd0);
    chk({tag, ".fw1"}, 64'(MulFlagsWrite), 64'd0);
    chk({tag, ".busy1"}, 64'(Busy), 64'd0);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; Start = 1'b0; Flush = 1'b0; SetFlags = 1'b0;
    Op = 3'b000; SrcA = '0; SrcB = '0; AccLo = '0; AccHi = '0;
    @(posedge clk); #1;
    chk("rst.busy", 64'(Busy), 64'd0);
    chk("rst.done", 64'(Done), 64'd0);
    chk("rst.lo", 64'(ResultLo), 64'd0);
    chk("rst.fw", 64'(MulFlagsWrite), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul7x6",  3'b000, 1'b1, 32'd7, 32'd6, 32'd0, 32'd0, 64'd42, 5'b00000);
    run_op("smull-1", 3'b110, 1'b1, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0,
           64'hFFFFFFFF_FFFFFFFF, 5'b10000);
    run_op("mulz",    3'b000, 1'b1, 32'h00010000, 32'h00010000, 32'd0, 32'd0,
           64'd0, 5'b01000);
    run_op("umull",   3'b100, 1'b1, 32'h00010000, 32'h00010000, 32'd0, 32'd0,
           64'h00000001_00000000, 5'b00000);
    run_op("umlal",   3'b101, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0,
           64'hFFFFFFFE_00000002, 5'b10000);
    run_op("mla",     3'b001, 1'b1, 32'd3, 32'd5, 32'd10, 32'hDEAD, 64'd25, 5'b00000);
    run_op("smlal",   3'b111, 1'b1, 32'hFFFFFFFE, 32'd3, 32'd10, 32'd0, 64'd4, 5'b00000);
    run_op("rsvd",    3'b010, 1'b1, 32'd7, 32'd6, 32'd100, 32'd0, 64'd42, 5'b00000);

    // Flush 10 cycles after accept: no Done, results untouched
    Op = 3'b000; SetFlags = 1'b1; SrcA = 32'd2; SrcB = 32'd3; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (Done) seen = 1'b1; end
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    chk("fl.busy", 64'(Busy), 64'd0);
    chk("fl.done", 64'(seen | Done), 64'd0);
    chk("fl.lo", 64'(ResultLo), 64'd42);
    run_op("postfl", 3'b100, 1'b0, 32'h12345678, 32'h10, 32'd0, 32'd0,
           64'h00000001_23456780, 5'b00000);

    run_op("fldone", 3'b000, 1'b1, 32'd5, 32'd5, 32'd0, 32'd0, 64'd25, 5'b00000, 1, 0);
    run_op("stdone", 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 64'd1, 5'b00000, 0, 1);

    // Reset mid-MUL clears everything at the next edge
    run_op("pre-rst", 3'b110, 1'b1, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0,
           64'hFFFFFFFF_FFFFFFFE, 5'b10000);
    Op = 3'b000; SrcA = 32'd9; SrcB = 32'd9; Start = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mrst.busy", 64'(Busy), 64'd0);
    chk("mrst.lo", 64'(ResultLo), 64'd0);
    chk("mrst.hi", 64'(ResultHi), 64'd0);
    chk("mrst.fl", 64'(MulFlags), 64'd0);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(posedge clk); #1; if (Done) seen = 1'b1; end
    chk("mrst.nodone", 64'(seen), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
